// File: rtl/patgen_pkg.sv
// Shared types and reset-table constants for pattern_seq_gen.
// Also provides the len clamp helper used when a run is started.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned RST_E0 = 1;
  localparam int unsigned RST_E1 = 3;
  localparam int unsigned RST_E2 = 4;
  localparam int unsigned RST_E3 = 2;

  function automatic int unsigned rst_entry(
    input int unsigned i
  );
    case (i)
      0:       return RST_E0;
      1:       return RST_E1;
      2:       return RST_E2;
      3:       return RST_E3;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned depth
  );
    return (len >= depth) ? depth - 1 : len;
  endfunction

endpackage

// File: rtl/patgen_table.sv
// Pattern table: register array, async reset to the legacy sequence,
// synchronous write port and combinational read port.
module patgen_table
  import patgen_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(rst_entry(unsigned'(i)));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pattern_seq_gen.sv
// Programmable pattern sequencer: table playback with per-entry hold.
// Define PATGEN_PINGPONG_EN to add the pingpong traversal input.
module pattern_seq_gen
  import patgen_pkg::*;
#(
  parameter  int WIDTH  = 3,
  parameter  int DEPTH  = 8,
  parameter  int HOLD_W = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              oneshot,
`ifdef PATGEN_PINGPONG_EN
  input  logic              pingpong,
`endif
  input  logic [AW:0]       len,
  input  logic [HOLD_W-1:0] hold,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  Q,
  output logic              valid,
  output logic [AW-1:0]     idx,
  output logic              done
);

  state_t            state, state_n;
  logic [AW-1:0]     idx_n, len_q;
  logic [HOLD_W-1:0] hcnt, hcnt_n, hold_q;
  logic              valid_n, done_n, load;
  logic              dir, dir_n;
  logic              pp_on, last;
  logic [WIDTH-1:0]  rd_data;

  patgen_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_n),
    .rd_data (rd_data)
  );

`ifdef PATGEN_PINGPONG_EN
  assign pp_on = pingpong && (len_q != '0);
`else
  assign pp_on = 1'b0;
`endif

  assign last = (idx == len_q);

  // dir: 0 = counting up, 1 = counting down (ping-pong only)
  always_comb begin
    state_n = state;
    idx_n   = '0;
    hcnt_n  = '0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    dir_n   = dir;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = RUN;
          valid_n = 1'b1;
          load    = 1'b1;
          dir_n   = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (hcnt != hold_q) begin
          hcnt_n  = hcnt + 1'b1;
          idx_n   = idx;
          valid_n = 1'b1;
        end else begin
          unique case (1'b1)
            pp_on && !dir && last: begin
              dir_n   = 1'b1;
              idx_n   = idx - 1'b1;
              valid_n = 1'b1;
            end
            pp_on && dir && (idx == '0): begin
              if (oneshot) begin
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                dir_n   = 1'b0;
                idx_n   = AW'(1);
                valid_n = 1'b1;
              end
            end
            pp_on && dir && (idx != '0): begin
              idx_n   = idx - 1'b1;
              valid_n = 1'b1;
            end
            !pp_on && last: begin
              dir_n = 1'b0;
              if (oneshot) begin
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                valid_n = 1'b1;
              end
            end
            default: begin
              idx_n   = idx + 1'b1;
              valid_n = 1'b1;
            end
          endcase
        end
      end
      DONE: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      hcnt   <= '0;
      Q      <= '0;
      valid  <= 1'b0;
      done   <= 1'b0;
      dir    <= 1'b0;
      len_q  <= '0;
      hold_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      hcnt  <= hcnt_n;
      Q     <= valid_n ? rd_data : '0;
      valid <= valid_n;
      done  <= done_n;
      dir   <= dir_n;
      if (load) begin
        len_q  <= AW'(clamp_len(32'(len), DEPTH));
        hold_q <= hold;
      end
    end
  end

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Self-checking bench for pattern_seq_gen against a sequence-level model.
// Define PATGEN_PINGPONG_EN to also exercise ping-pong traversal.
module tb_pattern_seq_gen;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 4;
  localparam int AW     = 3;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              enable  = 1'b0;
  logic              oneshot = 1'b0;
  logic              pp_in   = 1'b0;
  logic [AW:0]       len     = '0;
  logic [HOLD_W-1:0] hold    = '0;
  logic              wr_en   = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic [WIDTH-1:0]  Q;
  logic              valid;
  logic [AW-1:0]     idx;
  logic              done;

  wire [WIDTH+AW+1:0] obs = {Q, valid, idx, done};

  int checks = 0;
  int errors = 0;

  int               mt [DEPTH];
  bit               act;
  int               k, lc, hc;
  logic [WIDTH+AW+1:0] exp_v;

  always #5 clk = ~clk;

  pattern_seq_gen #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .oneshot  (oneshot),
`ifdef PATGEN_PINGPONG_EN
    .pingpong (pp_in),
`endif
    .len      (len),
    .hold     (hold),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .Q        (Q),
    .valid    (valid),
    .idx      (idx),
    .done     (done)
  );

  // Table position shown k edges after start; -1 once a one-shot is over.
  function automatic int pos_of(int kk, int l, int h, bit pp, bit os);
    int n;
    n = kk / (h + 1);
    if (pp && l > 0) begin
      if (os && n > 2 * l) return -1;
      n = n % (2 * l);
      return (n <= l) ? n : 2 * l - n;
    end
    if (os && n > l) return -1;
    return n % (l + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mt[i] = 0;
    mt[0] = 1; mt[1] = 3; mt[2] = 4; mt[3] = 2;
    act = 1'b0;
    k   = 0;
  endtask

  // Advance one clock edge and compute what the outputs must show after it.
  task automatic edge_step();
    int p;
    @(posedge clk);
    if (!enable) begin
      act   = 1'b0;
      exp_v = '0;
    end else begin
      if (!act) begin
        act = 1'b1;
        k   = 0;
        lc  = (int'(len) >= DEPTH) ? DEPTH - 1 : int'(len);
        hc  = int'(hold);
      end else begin
        k++;
      end
      p = pos_of(k, lc, hc, pp_in, oneshot);
      if (p < 0) exp_v = {WIDTH'(0), 1'b0, AW'(0), 1'b1};
      else       exp_v = {WIDTH'(mt[p]), 1'b1, AW'(p), 1'b0};
    end
    if (wr_en) mt[wr_addr] = int'(wr_data);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset got %h want %h", obs, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_step();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_cycle();
    len = 3; hold = 0; oneshot = 0; enable = 1;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL cycle[%0d] got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    enable = 0;
    edge_step();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL hold_clr got %h want %h", obs, exp_v);
    end
    len = 3; hold = 2; enable = 1;
    for (int i = 0; i < 14; i++) begin
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold[%0d] got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_oneshot();
    enable = 0;
    edge_step();
    len = 2; hold = 0; oneshot = 1; enable = 1;
    for (int i = 0; i < 7; i++) begin
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL oneshot[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    enable = 0;
    edge_step();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL oneshot_clr got %h want %h", obs, '0);
    end
    oneshot = 0;
  endtask

  task automatic test_drop_mid();
    len = 3; hold = 2; enable = 1;
    for (int i = 0; i < 8; i++) edge_step();
    checks++;
    if (Q !== 3'd4) begin
      errors++;
      $display("FAIL drop_pre got %0d want 4", Q);
    end
    enable = 0;
    edge_step();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL drop_clr got %h want %h", obs, '0);
    end
    enable = 1;
    edge_step();
    checks++;
    if (obs !== exp_v || Q !== 3'd1) begin
      errors++;
      $display("FAIL drop_restart got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_writes();
    int dat [4];
    dat = '{5, 6, 7, 0};
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = AW'(4 + i); wr_data = WIDTH'(dat[i]);
      edge_step();
    end
    wr_en = 0;
    len = 15; hold = 0; enable = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        wr_en = 1; wr_addr = 1; wr_data = 5;
      end else if (i == 9) begin
        wr_en = 1; wr_addr = 1; wr_data = 6;
      end else begin
        wr_en = 0;
      end
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL writes[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    wr_en = 0;
  endtask

  task automatic test_async_reset();
    enable = 0;
    edge_step();
    len = 3; hold = 1; enable = 1;
    wr_en = 1; wr_addr = 0; wr_data = 7;
    edge_step();
    wr_en = 0;
    for (int i = 0; i < 4; i++) edge_step();
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL areset got %h want %h", obs, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    edge_step();
    checks++;
    if (obs !== exp_v || Q !== 3'd1) begin
      errors++;
      $display("FAIL areset_tab got %h want %h", obs, exp_v);
    end
  endtask

`ifdef PATGEN_PINGPONG_EN
  task automatic test_pingpong();
    enable = 0;
    edge_step();
    pp_in = 1; len = 3; hold = 0; oneshot = 0; enable = 1;
    for (int i = 0; i < 12; i++) begin
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pp[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    enable = 0;
    edge_step();
    oneshot = 1; enable = 1;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pp_os[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    enable = 0;
    edge_step();
    pp_in = 0; oneshot = 0;
  endtask
`endif

  task automatic test_random();
    int r;
    enable = 0;
    edge_step();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (enable && r < 6) begin
        enable = 0;
      end else if (!enable) begin
        oneshot = 1'($urandom_range(0, 1));
`ifdef PATGEN_PINGPONG_EN
        pp_in = 1'($urandom_range(0, 1));
`endif
        if (r < 50) enable = 1;
      end
      len     = (AW + 1)'($urandom_range(0, 15));
      hold    = HOLD_W'($urandom_range(0, 3));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = WIDTH'($urandom_range(0, 7));
      edge_step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    wr_en = 0;
    enable = 0;
    pp_in = 0;
    edge_step();
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_hold();
    test_oneshot();
    test_drop_mid();
    test_writes();
    test_async_reset();
`ifdef PATGEN_PINGPONG_EN
    test_pingpong();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
